in_service_control: RTL and testbench

- Stage directly downstream of the priority resolver in the 8259A PIC.
- Consumes the resolver's one-hot `interrupt` word and raises INT to the CPU.
- Runs the two-pulse 8086-mode INTA acknowledge sequence: sets the In-Service Register (ISR), clears the acknowledged request bit, and drives the 8-bit vector.
- Clears ISR bits on EOI or automatic EOI. Its ISR output feeds back into the resolver.

---
 rtl/in_service_control.sv | 131 +++++++++++++
 tb/tb_in_service_control.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_service_control.sv
// In-service control stage of the 8259A PIC.
// Takes the resolver's one-hot winner and raises INT to the CPU. It then runs
// the two-pulse 8086-mode INTA sequence: it sets the ISR bit, pulses the IRR
// clear and drives the vector byte. ISR bits are retired by EOI or by AEOI.
module in_service_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt,
  input  logic [7:0] interrupt_req_reg,
  input  logic       inta_n,
  input  logic [7:0] end_of_interrupt,
  input  logic       auto_eoi_config,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } state_t;

  state_t     state;
  logic       inta_n_q;
  logic [2:0] ack_level;
  logic       spurious;

  logic [7:0] masked_req;
  logic       valid_req;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] req_level;
  logic [7:0] set_mask;
  logic [7:0] aeoi_clear;

  // Qualify the resolver winner against IRR and detect INTA edges
  always_comb begin
    masked_req = interrupt & interrupt_req_reg;
    valid_req  = |masked_req;
    inta_fall  = ~inta_n & inta_n_q;
    inta_rise  = inta_n & ~inta_n_q;
  end

  // Binary-encode the qualified one-hot request; with nothing pending this
  // yields level 7, which is what a spurious acknowledge reports
  always_comb begin
    req_level = 3'd7;
    for (int unsigned i = 0; i < 8; i++) begin
      if (masked_req[i]) begin
        req_level = i[2:0];
      end
    end
  end

  // ISR set and auto-EOI clear masks for the current edge
  always_comb begin
    set_mask   = '0;
    aeoi_clear = '0;
    if (state == IDLE && inta_fall && valid_req) begin
      set_mask = 8'h01 << req_level;
    end
    if (state == ACK2 && inta_rise && auto_eoi_config && !spurious) begin
      aeoi_clear = 8'h01 << ack_level;
    end
  end

  // Acknowledge sequencer with registered outputs and ISR bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                   <= IDLE;
      inta_n_q                <= 1'b1;
      ack_level               <= '0;
      spurious                <= 1'b0;
      int_out                 <= 1'b0;
      in_service_register     <= '0;
      clear_interrupt_request <= '0;
      data_out                <= '0;
      data_out_en             <= 1'b0;
    end else begin
      inta_n_q                <= inta_n;
      clear_interrupt_request <= '0;
      // Set is applied after the clears so it wins on a colliding bit
      in_service_register     <= (in_service_register & ~end_of_interrupt & ~aeoi_clear)
                                 | set_mask;
      case (state)
        IDLE: begin
          int_out <= valid_req;
          if (inta_fall) begin
            ack_level <= req_level;
            spurious  <= ~valid_req;
            int_out   <= 1'b0;
            if (valid_req) begin
              clear_interrupt_request <= 8'h01 << req_level;
            end
            state <= ACK1;
          end
        end
        ACK1: begin
          int_out <= 1'b0;
          if (inta_rise) begin
            state <= WAIT2;
          end
        end
        WAIT2: begin
          int_out <= 1'b0;
          if (inta_fall) begin
            data_out    <= {vector_base, ack_level};
            data_out_en <= 1'b1;
            state       <= ACK2;
          end
        end
        ACK2: begin
          int_out <= 1'b0;
          if (inta_rise) begin
            data_out_en <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// Bench for in_service_control: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_in_service_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt;
  logic [7:0] interrupt_req_reg;
  logic       inta_n;
  logic [7:0] end_of_interrupt;
  logic       auto_eoi_config;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] clear_interrupt_request;
  logic [7:0] data_out;
  logic       data_out_en;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [7:0] m_isr;
  bit       m_int;
  bit [7:0] m_clr;
  bit [7:0] m_dout;
  bit       m_den;
  int       m_edges;   // INTA edges seen in the current acknowledge: 0..3
  int       m_lvl;
  bit       m_spur;
  bit       m_prev;

  in_service_control dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .interrupt               (interrupt),
    .interrupt_req_reg       (interrupt_req_reg),
    .inta_n                  (inta_n),
    .end_of_interrupt        (end_of_interrupt),
    .auto_eoi_config         (auto_eoi_config),
    .vector_base             (vector_base),
    .int_out                 (int_out),
    .in_service_register     (in_service_register),
    .clear_interrupt_request (clear_interrupt_request),
    .data_out                (data_out),
    .data_out_en             (data_out_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int level_of(input bit [7:0] m);
    int lvl = 7;
    for (int i = 0; i < 8; i++) begin
      if (m == (8'h01 << i)) lvl = i;
    end
    return lvl;
  endfunction

  // One acknowledge is four INTA edges: fall, rise, fall, rise.
  task automatic model_step;
    bit       fall;
    bit       rise;
    bit [7:0] req;
    bit [7:0] setm;
    bit [7:0] aeoi;
    if (!reset_n) begin
      m_isr = 0; m_int = 0; m_clr = 0; m_dout = 0; m_den = 0;
      m_edges = 0; m_prev = 1;
      return;
    end
    fall = !inta_n && m_prev;
    rise = inta_n && !m_prev;
    req  = interrupt & interrupt_req_reg;
    setm = 0;
    aeoi = 0;
    m_clr = 0;
    if (m_edges == 0) begin
      m_int = (req != 0);
      if (fall) begin
        m_spur = (req == 0);
        m_lvl  = m_spur ? 7 : level_of(req);
        if (!m_spur) begin
          setm  = 8'h01 << m_lvl;
          m_clr = setm;
        end
        m_int   = 0;
        m_edges = 1;
      end
    end else if (m_edges == 1) begin
      m_int = 0;
      if (rise) m_edges = 2;
    end else if (m_edges == 2) begin
      m_int = 0;
      if (fall) begin
        m_dout  = vector_base * 8 + m_lvl;
        m_den   = 1;
        m_edges = 3;
      end
    end else begin
      m_int = 0;
      if (rise) begin
        m_den = 0;
        if (auto_eoi_config && !m_spur) aeoi = 8'h01 << m_lvl;
        m_edges = 0;
      end
    end
    m_isr  = (m_isr & ~end_of_interrupt & ~aeoi) | setm;
    m_prev = inta_n;
  endtask

  // Apply current inputs for one clock, then compare away from the edge
  task automatic cycle;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("int_out", {7'd0, int_out}, {7'd0, m_int});
    check_eq("isr", in_service_register, m_isr);
    check_eq("clr_req", clear_interrupt_request, m_clr);
    check_eq("data_out", data_out, m_dout);
    check_eq("data_out_en", {7'd0, data_out_en}, {7'd0, m_den});
  endtask

  task automatic idle_inputs;
    reset_n = 1; interrupt = 8'h80; interrupt_req_reg = 0; inta_n = 1;
    end_of_interrupt = 0; auto_eoi_config = 0; vector_base = 0;
  endtask

  task automatic do_reset;
    reset_n = 0;
    cycle();
    cycle();
    reset_n = 1;
  endtask

  initial begin
    int hold;
    int lvl;
    m_prev = 1; m_edges = 0; m_lvl = 7; m_spur = 0;
    idle_inputs();
    do_reset();
    check_eq("reset_isr", in_service_register, 8'h00);
    check_eq("reset_den", {7'd0, data_out_en}, 8'h00);

    // Unqualified bit 7 from the resolver must not raise INT
    cycle(); cycle();
    check_eq("no_req_int", {7'd0, int_out}, 8'h00);
    check_eq("no_req_isr", in_service_register, 8'h00);

    // Normal acknowledge of level 2
    interrupt = 8'h04; interrupt_req_reg = 8'h0C; vector_base = 5'b01000;
    cycle();
    check_eq("int_rise", {7'd0, int_out}, 8'h01);
    inta_n = 0; cycle();
    check_eq("ack_isr", in_service_register, 8'h04);
    check_eq("ack_clr", clear_interrupt_request, 8'h04);
    cycle();
    check_eq("clr_one_cycle", clear_interrupt_request, 8'h00);
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    check_eq("vector", data_out, 8'h42);
    check_eq("vector_en", {7'd0, data_out_en}, 8'h01);
    inta_n = 1; cycle();
    check_eq("vec_en_off", {7'd0, data_out_en}, 8'h00);
    check_eq("isr_kept", in_service_register, 8'h04);
    end_of_interrupt = 8'h04; cycle();
    end_of_interrupt = 0; interrupt_req_reg = 0; interrupt = 8'h80; cycle();
    check_eq("eoi_clear", in_service_register, 8'h00);

    // Same sequence with automatic EOI
    interrupt = 8'h04; interrupt_req_reg = 8'h0C; auto_eoi_config = 1;
    cycle();
    inta_n = 0; cycle(); cycle();
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    check_eq("aeoi_vec", data_out, 8'h42);
    inta_n = 1; cycle();
    check_eq("aeoi_isr", in_service_register, 8'h00);
    check_eq("aeoi_en", {7'd0, data_out_en}, 8'h00);
    auto_eoi_config = 0; interrupt_req_reg = 0; interrupt = 8'h80;
    cycle(); cycle();

    // Spurious: request withdrawn before the first INTA fall
    interrupt = 8'h04; interrupt_req_reg = 8'h04; vector_base = 5'b00001;
    cycle();
    interrupt = 8'h80; interrupt_req_reg = 0; cycle();
    inta_n = 0; cycle();
    check_eq("spur_isr", in_service_register, 8'h00);
    check_eq("spur_clr", clear_interrupt_request, 8'h00);
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    check_eq("spur_vec", data_out, 8'h0F);
    inta_n = 1; cycle(); cycle();

    // EOI colliding with a set of the same bit
    interrupt = 8'h10; interrupt_req_reg = 8'h10; vector_base = 5'b00010;
    cycle();
    inta_n = 0; cycle();
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    inta_n = 1; cycle(); cycle();
    check_eq("isr_b4", in_service_register, 8'h10);
    inta_n = 0; end_of_interrupt = 8'h10; cycle();
    check_eq("set_wins", in_service_register, 8'h10);
    end_of_interrupt = 0;
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    inta_n = 1; interrupt_req_reg = 0; interrupt = 8'h80; cycle();
    end_of_interrupt = 8'h10; cycle();
    check_eq("eoi_b4", in_service_register, 8'h00);
    end_of_interrupt = 0; cycle();

    // Reset in the gap between pulses abandons the acknowledge
    interrupt = 8'h02; interrupt_req_reg = 8'h02;
    cycle();
    inta_n = 0; cycle();
    inta_n = 1; cycle();
    reset_n = 0; cycle();
    check_eq("rst_isr", in_service_register, 8'h00);
    check_eq("rst_int", {7'd0, int_out}, 8'h00);
    check_eq("rst_den", {7'd0, data_out_en}, 8'h00);
    reset_n = 1; inta_n = 0; cycle();
    check_eq("new_first", in_service_register, 8'h02);
    check_eq("new_first_clr", clear_interrupt_request, 8'h02);
    inta_n = 1; cycle();
    inta_n = 0; cycle();
    inta_n = 1; cycle();
    end_of_interrupt = 8'hFF; interrupt_req_reg = 0; cycle();
    end_of_interrupt = 0;

    // Random traffic
    hold = 2;
    for (int n = 0; n < 2000; n++) begin
      if (hold == 0) begin
        inta_n = ~inta_n;
        hold = $urandom_range(1, 4);
      end else begin
        hold--;
      end
      lvl = $urandom_range(0, 7);
      interrupt = 8'h01 << lvl;
      interrupt_req_reg = 8'($urandom);
      if ($urandom_range(0, 3) != 0) interrupt_req_reg[lvl] = 1'b1;
      if ($urandom_range(0, 5) == 0) interrupt_req_reg = 0;
      end_of_interrupt = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      auto_eoi_config = $urandom_range(0, 1) == 1;
      vector_base = 5'($urandom);
      reset_n = $urandom_range(0, 99) != 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
